// File: rtl/avalon_bram_burst_pkg.sv
// Shared types and helpers for the Avalon-MM burst BRAM agent.
// Optional SLVERR response path is enabled by defining BRAM_RESP_EN.
package avalon_bram_pkg;

  typedef enum logic [1:0] {
    RESET,
    IDLE,
    RD_BURST,
    WR_BURST
  } bram_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Out-of-range burst lengths (0 or above the maximum) degrade to single beats.
  function automatic int unsigned clamp_burst(input int unsigned bc, input int unsigned max_bc);
    return ((bc == 32'd0) || (bc > max_bc)) ? 32'd1 : bc;
  endfunction

endpackage

// File: rtl/avalon_bram_burst_if.sv
// Avalon-MM agent bus bundle for avalon_bram_burst; the response signal
// exists only when BRAM_RESP_EN is defined.
interface avalon_bram_burst_if
  import avalon_bram_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BURSTCOUNT_W = 4
) ();

  logic [ADDR_W-1:0]       address;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic                    read;
  logic                    write;
  logic [DATA_W/8-1:0]     byteenable;
  logic [DATA_W-1:0]       writedata;
  logic [DATA_W-1:0]       readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

`ifdef BRAM_RESP_EN
  logic [1:0]              response;

  modport slave (
    input  address, burstcount, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest, response
  );
  modport master (
    output address, burstcount, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest, response
  );
`else
  modport slave (
    input  address, burstcount, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
  modport master (
    output address, burstcount, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );
`endif

endinterface

// File: rtl/avalon_bram_burst_bytelane.sv
// One 8-bit byte lane of the burst BRAM: single-port synchronous RAM,
// registered read output, contents deliberately not reset.
module bram_bytelane #(
  parameter int unsigned RAM_ADD_W = 11
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [RAM_ADD_W-1:0] i_addr,
  input  logic [7:0]           i_wdata,
  output logic [7:0]           o_rdata
);

  logic [7:0] r_mem [2**RAM_ADD_W];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avalon_bram_burst.sv
// Avalon-MM burst BRAM agent: FSM, burst/address counters and read-return path.
// Define BRAM_RESP_EN for SLVERR on wrapped read beats and dropping of wrapped write beats.
module avalon_bram_burst
  import avalon_bram_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RAM_ADD_W    = 11,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BURSTCOUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  avalon_bram_burst_if.slave bus
);

  localparam int unsigned LANES     = DATA_W / 8;
  localparam int unsigned LSB       = $clog2(LANES);
  localparam int unsigned MAX_BURST = 2 ** (BURSTCOUNT_W - 1);
  localparam logic [RAM_ADD_W-1:0] LAST_WORD = '1;

  bram_state_t             r_state, w_state_nxt;
  logic [RAM_ADD_W-1:0]    r_addr, w_addr_nxt, w_ram_addr, w_widx;
  logic [BURSTCOUNT_W-1:0] r_cnt, w_cnt_nxt, w_first_cnt;
  logic                    r_rvalid, w_rvalid_nxt;
  logic                    w_ram_re, w_waitreq;
  logic [LANES-1:0]        w_ram_we;
  logic [DATA_W-1:0]       w_ram_q;
  logic                    w_unused_addr;
`ifdef BRAM_RESP_EN
  logic                    r_wrap, w_wrap_nxt;
  logic [1:0]              r_resp, w_resp_nxt;
`endif

  assign w_widx        = bus.address[LSB +: RAM_ADD_W];
  assign w_unused_addr = ^bus.address;
  assign w_first_cnt   = BURSTCOUNT_W'(clamp_burst(32'(bus.burstcount), MAX_BURST));

  // r_cnt holds beats still to come after the current one; r_addr is the next word.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_cnt_nxt    = r_cnt;
    w_rvalid_nxt = 1'b0;
    w_ram_re     = 1'b0;
    w_ram_we     = '0;
    w_ram_addr   = r_addr;
    w_waitreq    = 1'b0;
`ifdef BRAM_RESP_EN
    w_wrap_nxt   = r_wrap;
    w_resp_nxt   = RESP_OKAY;
`endif
    unique case (r_state)
      RESET: begin
        w_waitreq   = 1'b1;
        w_state_nxt = IDLE;
      end
      IDLE: begin
        w_ram_addr = w_widx;
        w_addr_nxt = w_widx + RAM_ADD_W'(1);
        w_cnt_nxt  = w_first_cnt - BURSTCOUNT_W'(1);
`ifdef BRAM_RESP_EN
        w_wrap_nxt = (w_widx == LAST_WORD);
`endif
        if (bus.write) begin
          w_ram_we = bus.byteenable;
          if (w_first_cnt > BURSTCOUNT_W'(1)) w_state_nxt = WR_BURST;
        end else if (bus.read) begin
          w_ram_re     = 1'b1;
          w_rvalid_nxt = 1'b1;
          if (w_first_cnt > BURSTCOUNT_W'(1)) w_state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        w_waitreq    = 1'b1;
        w_ram_re     = 1'b1;
        w_rvalid_nxt = 1'b1;
        w_addr_nxt   = r_addr + RAM_ADD_W'(1);
        w_cnt_nxt    = r_cnt - BURSTCOUNT_W'(1);
`ifdef BRAM_RESP_EN
        w_resp_nxt   = r_wrap ? RESP_SLVERR : RESP_OKAY;
        w_wrap_nxt   = r_wrap | (r_addr == LAST_WORD);
`endif
        if (r_cnt == BURSTCOUNT_W'(1)) w_state_nxt = IDLE;
      end
      WR_BURST: begin
        if (bus.write) begin
`ifdef BRAM_RESP_EN
          w_ram_we   = r_wrap ? '0 : bus.byteenable;
          w_wrap_nxt = r_wrap | (r_addr == LAST_WORD);
`else
          w_ram_we   = bus.byteenable;
`endif
          w_addr_nxt = r_addr + RAM_ADD_W'(1);
          w_cnt_nxt  = r_cnt - BURSTCOUNT_W'(1);
          if (r_cnt == BURSTCOUNT_W'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= RESET;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
`ifdef BRAM_RESP_EN
      r_wrap   <= 1'b0;
      r_resp   <= RESP_OKAY;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_rvalid_nxt;
`ifdef BRAM_RESP_EN
      r_wrap   <= w_wrap_nxt;
      r_resp   <= w_resp_nxt;
`endif
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bram_bytelane #(.RAM_ADD_W(RAM_ADD_W)) u_lane (
      .i_clk   (clk),
      .i_we    (w_ram_we[g]),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (bus.writedata[g*8 +: 8]),
      .o_rdata (w_ram_q[g*8 +: 8])
    );
  end

  // RAM output is not reset, so readdata is gated to read zero outside valid beats.
  assign bus.readdata      = r_rvalid ? w_ram_q : '0;
  assign bus.readdatavalid = r_rvalid;
  assign bus.waitrequest   = w_waitreq;
`ifdef BRAM_RESP_EN
  assign bus.response      = r_resp;
`endif

endmodule

// File: tb/tb_avalon_bram_burst.sv
// Self-checking bench for avalon_bram_burst against a word-array/queue reference model.
// Honours BRAM_RESP_EN in the same way as the design.
module tb_avalon_bram_burst;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RAM_W  = 11;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BC_W   = 4;
  localparam int unsigned DEPTH  = 2 ** RAM_W;
  localparam int unsigned MAXB   = 2 ** (BC_W - 1);

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int unsigned cyc;
  } beat_t;

  logic clk;
  logic reset_n;

  avalon_bram_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURSTCOUNT_W(BC_W)) bus ();

  avalon_bram_burst #(
    .DATA_W       (DATA_W),
    .RAM_ADD_W    (RAM_W),
    .ADDR_W       (ADDR_W),
    .BURSTCOUNT_W (BC_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_beats  = 0;
  int unsigned wait_hi  = 0;
  int unsigned cyc      = 0;

  logic [31:0] mem [DEPTH];
  beat_t       exp_q [$];
  int unsigned rd_busy    = 0;
  int unsigned wr_rem     = 0;
  int unsigned wr_pos     = 0;
  bit          pend_reset = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned clampn(input int unsigned bc);
    return (bc == 0 || bc > MAXB) ? 1 : bc;
  endfunction

  function automatic void mdl_write(input int unsigned pos, input logic [31:0] d, input logic [3:0] be);
    int unsigned idx;
`ifdef BRAM_RESP_EN
    if (pos >= DEPTH) return;
`endif
    idx = pos % DEPTH;
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // One clock: check waitrequest before the edge, then apply the edge to the model.
  task automatic step(output bit acc, output bit busy_pre);
    bit          exp_w;
    int unsigned n, a;
    beat_t       b;
    exp_w    = !reset_n || pend_reset || (rd_busy > 0);
    busy_pre = exp_w;
    if (bus.waitrequest) wait_hi++;
    chk("waitrequest", bus.waitrequest, exp_w);
    if (bus.read && bus.write) begin
      $display("FAIL protocol: read and write asserted together");
      $fatal(1);
    end
    acc = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset_n) begin
    end else if (pend_reset) begin
      pend_reset = 1'b0;
    end else if (rd_busy > 0) begin
      rd_busy--;
    end else if (wr_rem > 0) begin
      if (bus.write) begin
        mdl_write(wr_pos, bus.writedata, bus.byteenable);
        wr_pos++;
        wr_rem--;
        acc = 1'b1;
      end
    end else if (bus.write) begin
      n = clampn(32'(bus.burstcount));
      a = (bus.address >> 2) % DEPTH;
      mdl_write(a, bus.writedata, bus.byteenable);
      if (n > 1) begin
        wr_rem = n - 1;
        wr_pos = a + 1;
      end
      acc = 1'b1;
    end else if (bus.read) begin
      n = clampn(32'(bus.burstcount));
      a = (bus.address >> 2) % DEPTH;
      for (int k = 0; k < int'(n); k++) begin
        b.data = mem[(a + k) % DEPTH];
        b.resp = 2'b00;
`ifdef BRAM_RESP_EN
        if (a + k >= DEPTH) b.resp = 2'b10;
`endif
        b.cyc = cyc + k;
        exp_q.push_back(b);
      end
      rd_busy = n - 1;
      acc = 1'b1;
    end
  endtask

  task automatic idle(input int unsigned n);
    bit acc, bp;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    repeat (n) step(acc, bp);
  endtask

  // Present a command or write beat and hold it until accepted (bounded).
  task automatic issue(input bit is_wr, input int unsigned waddr, input int unsigned bc,
                       input logic [3:0] be, input logic [31:0] d);
    bit acc, bp;
    bus.address    = 32'(waddr << 2);
    bus.burstcount = bc[BC_W-1:0];
    bus.byteenable = be;
    bus.writedata  = d;
    bus.write      = is_wr;
    bus.read       = !is_wr;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) step(acc, bp);
    chk("accept", acc, 1'b1);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic assert_reset();
    reset_n    = 1'b0;
    pend_reset = 1'b1;
    rd_busy    = 0;
    wr_rem     = 0;
    exp_q.delete();
  endtask

  task automatic set_rand();
    int unsigned w, r;
    bus.byteenable = 4'($urandom);
    bus.writedata  = $urandom;
    bus.burstcount = BC_W'($urandom);
    if ($urandom_range(0, 3) == 0) w = DEPTH - 1 - $urandom_range(0, 7);
    else                           w = $urandom_range(0, DEPTH - 1);
    bus.address = 32'(w << 2) | ($urandom & 32'hFFFF_E003);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    if (wr_rem > 0) begin
      bus.write = ($urandom_range(0, 3) != 0);
      bus.read  = !bus.write && ($urandom_range(0, 1) == 1);
    end else begin
      r = $urandom_range(0, 9);
      if (r >= 2 && r < 6) bus.write = 1'b1;
      else if (r >= 6)     bus.read  = 1'b1;
    end
  endtask

  always @(negedge clk) begin : mon
    beat_t b;
    bit    exp_v;
    exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (bus.readdatavalid) n_beats++;
    if (exp_v || bus.readdatavalid) begin
      chk("readdatavalid", bus.readdatavalid, exp_v);
      if (exp_v) begin
        b = exp_q.pop_front();
        chk("readdata", bus.readdata, b.data);
`ifdef BRAM_RESP_EN
        chk("response", bus.response, b.resp);
`endif
      end
    end
  end

  initial begin
    bit          acc, bp;
    int unsigned c0, w0, nb0;
    reset_n        = 1'b1;
    bus.address    = '0;
    bus.burstcount = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.byteenable = '0;
    bus.writedata  = '0;

    // Reset and release
    #2;
    assert_reset();
    #1;
    chk("rst_waitrequest", bus.waitrequest, 1'b1);
    chk("rst_readdatavalid", bus.readdatavalid, 1'b0);
    chk("rst_readdata", bus.readdata, 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(1);
    chk("release_waitrequest", bus.waitrequest, 1'b0);

    // Fill the whole RAM with write bursts, random idle gaps inside bursts
    for (int i = 0; i < int'(DEPTH / MAXB); i++) begin
      issue(1'b1, i * MAXB, MAXB, 4'hF, $urandom);
      for (int k = 1; k < int'(MAXB); k++) begin
        if ($urandom_range(0, 7) == 0) idle(1);
        issue(1'b1, $urandom, 0, 4'hF, $urandom);
      end
    end

    // Single write then read of the same word
    issue(1'b1, 32'h10 >> 2, 1, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10 >> 2, 1, 4'hF, 32'h0);
    idle(2);

    // Byte lanes
    issue(1'b1, 32'h20 >> 2, 1, 4'hF, 32'h11223344);
    issue(1'b1, 32'h20 >> 2, 1, 4'b0101, 32'hAABBCCDD);
    issue(1'b0, 32'h20 >> 2, 1, 4'hF, 32'h0);
    idle(2);

    // Write burst 8 with one gap, then back-to-back read bursts 8 and 4
    issue(1'b1, 32'h100 >> 2, 8, 4'hF, 32'd0);
    for (int k = 1; k < 8; k++) begin
      if (k == 4) idle(1);
      issue(1'b1, $urandom, 3, 4'hF, 32'(k));
    end
    issue(1'b0, 32'h100 >> 2, 8, 4'hF, 32'h0);
    c0 = cyc;
    w0 = wait_hi;
    issue(1'b0, 32'h100 >> 2, 4, 4'hF, 32'h0);
    chk("b2b_accept_gap", cyc - c0, 8);
    chk("b2b_wait_cycles", wait_hi - w0, 7);
    idle(6);

    // Burst across the top of the word space
    issue(1'b1, DEPTH - 2, 4, 4'hF, 32'hC0DE0000);
    for (int k = 1; k < 4; k++) issue(1'b1, 0, 0, 4'hF, 32'hC0DE0000 + 32'(k));
    issue(1'b0, DEPTH - 2, 4, 4'hF, 32'h0);
    issue(1'b0, 0, 2, 4'hF, 32'h0);
    idle(4);

    // Randomised traffic, holding commands while waitrequest is expected
    set_rand();
    for (int i = 0; i < 1500; i++) begin
      step(acc, bp);
      if (!((bus.read || bus.write) && !acc && bp)) set_rand();
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    for (int i = 0; i < int'(MAXB) && wr_rem > 0; i++) issue(1'b1, 0, 0, 4'hF, $urandom);
    idle(10);

    // Reset during a read burst, after three beats
    issue(1'b0, 32'h100 >> 2, 8, 4'hF, 32'h0);
    idle(3);
    nb0 = n_beats;
    assert_reset();
    #1;
    chk("abort_readdatavalid", bus.readdatavalid, 1'b0);
    idle(2);
    reset_n = 1'b1;
    idle(12);
    chk("abort_no_more_beats", n_beats - nb0, 0);

    // burstcount 0 yields one beat; RAM content survived the reset
    nb0 = n_beats;
    issue(1'b0, 32'h100 >> 2, 0, 4'hF, 32'h0);
    idle(4);
    chk("bc0_beat_count", n_beats - nb0, 1);
    issue(1'b0, 32'h20 >> 2, 1, 4'hF, 32'h0);
    idle(4);
    chk("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
